// File: rtl/spi_slave_xcvr.sv
// ---------------------------------------------------------------------------
// spi_slave_xcvr -- SPI slave transceiver, one word of DW bits per transfer,
// LSB first on both mosi and miso, all logic in the Clk_i domain.
//
// The SPI bus (sck/mosi/ss in, shared miso out) is presented as flat ports:
//   SpisSck_i, SpisMosi_i   bus clock and master data (asynchronous)
//   SpisSs_i[NSS-1:0]       slave selects, this slave answers to bit ID
//   SpisMiso_o              tx[0] while selected, high-impedance otherwise
//   SpisMisoOe_o            1 while SpisMiso_o is actively driven
// Local side:
//   Tx_i/TxValid_i/TxReady_o  word to send, ready while holding reg is empty
//   Rcvd_o/RxValid_o/RxAck_i  last received word, valid until acknowledged
//   Ovr_o                     sticky overrun flag
//
// Optional feature: define SPI_SLAVE_OVERRUN_EN to enable the overrun flag;
// without it Ovr_o is 0 and a new word simply overwrites Rcvd_o.
//
// sck phases must last at least 4 Clk_i periods.
// ---------------------------------------------------------------------------
module spi_slave_xcvr #(
    parameter int ID   = 0,
    parameter int NSS  = 2,
    parameter int DW   = 8,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic          Clk_i,
    input  logic          Rst_ni,
    input  logic          SpisSck_i,
    input  logic          SpisMosi_i,
    input  logic [NSS-1:0] SpisSs_i,
    output logic          SpisMiso_o,
    output logic          SpisMisoOe_o,
    input  logic [DW-1:0] Tx_i,
    input  logic          TxValid_i,
    output logic          TxReady_o,
    output logic [DW-1:0] Rcvd_o,
    output logic          RxValid_o,
    input  logic          RxAck_i,
    output logic          Ovr_o
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    // Rising sck samples when CPOL==CPHA, falling sck otherwise.
    localparam bit SAMPLE_RISE = (CPOL == CPHA);

    // Only our own select line matters; the others are ignored.
    logic unused_ss;
    assign unused_ss = ^SpisSs_i;

    logic [1:0]    sck_sync_q, mosi_sync_q, ss_sync_q;
    logic          sck_prev_q, ss_prev_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rx_q, tx_q, hold_q, rcvd_q;
    logic          hold_full_q, rx_valid_q;

    logic          sck_s, ss_s, sck_rise, sck_fall, ss_rise, ss_fall;
    logic          sample_en, shift_edge, shift_en, word_done, word_start, tx_load;
    logic [DW-1:0] rx_next;

    always_comb begin
        sck_s      = sck_sync_q[1];
        ss_s       = ss_sync_q[1];
        sck_rise   = sck_s & ~sck_prev_q;
        sck_fall   = ~sck_s & sck_prev_q;
        ss_rise    = ss_s & ~ss_prev_q;
        ss_fall    = ~ss_s & ss_prev_q;
        sample_en  = (SAMPLE_RISE ? sck_rise : sck_fall) & ss_s;
        shift_edge = (SAMPLE_RISE ? sck_fall : sck_rise) & ss_s;
        word_done  = sample_en && (cnt_q == CW'(DW - 1));
        rx_next    = {mosi_sync_q[1], rx_q[DW-1:1]};
        // With the counter at 0 a shift edge is either the CPHA=1 word start
        // (load, no shift) or, for CPHA=0, the trailing edge after the last
        // sample: the next word's bit 0 is already in place and must survive.
        shift_en   = shift_edge && (cnt_q != '0);
        if (CPHA)
            word_start = shift_edge && (cnt_q == '0);
        else
            word_start = ss_rise | word_done;
        tx_load    = TxValid_i & ~hold_full_q;
    end

    always_ff @(posedge Clk_i) begin
        if (!Rst_ni) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rcvd_q      <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], SpisSck_i};
            mosi_sync_q <= {mosi_sync_q[0], SpisMosi_i};
            ss_sync_q   <= {ss_sync_q[0], SpisSs_i[ID]};
            sck_prev_q  <= sck_s;
            ss_prev_q   <= ss_s;

            // Deselect mid-word throws away the partial word in both directions.
            if (ss_fall) begin
                cnt_q <= '0;
                rx_q  <= '0;
                tx_q  <= '0;
            end else begin
                if (sample_en) begin
                    rx_q  <= rx_next;
                    cnt_q <= word_done ? '0 : cnt_q + 1'b1;
                end
                if (word_start)
                    tx_q <= hold_full_q ? hold_q : '0;
                else if (shift_en)
                    tx_q <= {1'b0, tx_q[DW-1:1]};
            end

            // A load can only be accepted while holding is empty, so a
            // simultaneous word start moves zeros and the new word stays put.
            if (tx_load) begin
                hold_q      <= Tx_i;
                hold_full_q <= 1'b1;
            end else if (word_start) begin
                hold_q      <= '0;
                hold_full_q <= 1'b0;
            end

            if (word_done) begin
                rcvd_q     <= rx_next;
                rx_valid_q <= 1'b1;
            end else if (RxAck_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic ovr_q;
    always_ff @(posedge Clk_i) begin
        if (!Rst_ni)
            ovr_q <= 1'b0;
        else if (word_done && rx_valid_q && !RxAck_i)
            ovr_q <= 1'b1;
        else if (RxAck_i && !word_done)
            ovr_q <= 1'b0;
    end
    assign Ovr_o = ovr_q;
`else
    assign Ovr_o = 1'b0;
`endif

    assign TxReady_o    = ~hold_full_q;
    assign Rcvd_o       = rcvd_q;
    assign RxValid_o    = rx_valid_q;
    assign SpisMisoOe_o = ss_s;
    assign SpisMiso_o   = ss_s ? tx_q[0] : 1'bz;

endmodule

// File: doc/spi_slave_xcvr.md
SPI_SLAVE_XCVR -- requirements
Module: spi_slave_xcvr

Interface
REQ-001 Parameter ID, default 0: index of the ss line this slave answers to in Spis.ss.
REQ-002 Parameter DW, default 8: word width in bits, legal range 2..32.
REQ-003 Parameter CPOL, default 0: sck idle level.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 Clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-006 Rst_ni  input  1  reset, synchronous, active-low.
REQ-007 Spis  SPIbus.Slave  -  sck/mosi/ss inputs and shared miso output; slave selected when Spis.ss[ID]==1.
REQ-008 Tx_i  input  DW  word to transmit.
REQ-009 TxValid_i  input  1  Tx_i valid.
REQ-010 TxReady_o  output  1  tx holding register empty.
REQ-011 Rcvd_o  output  DW  last received word.
REQ-012 RxValid_o  output  1  Rcvd_o holds an unacknowledged word.
REQ-013 RxAck_i  input  1  consumer acknowledges Rcvd_o.
REQ-014 Ovr_o  output  1  sticky receive-overrun flag.

Function
REQ-015 sck, mosi, ss[ID] each pass through a 2-flop synchroniser before use.
REQ-016 Sample enable = synced sck edge of type rising when CPOL==CPHA, falling otherwise, gated by synced ss[ID]==1; shift enable = the opposite edge, same gating.
REQ-017 Bit order LSB first on both mosi and miso.
REQ-018 Bit counter 0..DW-1 increments on each sample enable; wraps DW-1 -> 0 on the DW-th sample (word complete).
REQ-019 Rx shift register: {mosi_sync, rx[DW-1:1]} on each sample enable.
REQ-020 On word complete: Rcvd_o <= full shifted word and RxValid_o <= 1 at the next Clk_i edge (one cycle after the sample enable).
REQ-021 RxValid_o clears on RxAck_i==1 unless a word completes in the same cycle, in which case it stays 1 with the new word.
REQ-022 Tx handshake: holding register loads Tx_i when TxValid_i && TxReady_o; TxReady_o deasserts the following cycle.
REQ-023 Word start (CPHA=0: synced ss rising edge, or word complete while still selected; CPHA=1: first shift enable with bit counter 0): holding moves to tx shift register, TxReady_o reasserts next cycle; if holding empty, shift register loads all zeros.
REQ-024 Load at word start and TxValid_i handshake in the same cycle: old holding word moves to shift register, new Tx_i enters holding.
REQ-025 Shift enable (except the word-start shift enable when CPHA=1) shifts tx right by one; miso = tx[0].
REQ-026 Spis.miso = tx[0] while synced ss[ID]==1, else high-impedance.
REQ-027 Synced ss[ID] falling mid-word: bit counter -> 0, partial rx and tx shift contents discarded, no RxValid_o, holding register unaffected.
REQ-028 Operating constraint: each sck phase >= 4 Clk_i periods.

Reset
REQ-029 Rst_ni==0 at a Clk_i edge: synchronisers, bit counter, rx/tx shift registers, holding register, Rcvd_o = 0; RxValid_o = 0; Ovr_o = 0; TxReady_o = 1; miso high-impedance.
REQ-030 Reset mid-word aborts the word; the first word after reset begins at the next word start.

Configuration
REQ-031 Macro SPI_SLAVE_OVERRUN_EN defined: Ovr_o sets when a word completes while RxValid_o==1 and RxAck_i==0 in that cycle; stays set until a cycle with RxAck_i==1 and no word completion.
REQ-032 Macro undefined: Ovr_o tied 0; a new word silently overwrites Rcvd_o.

Verification
REQ-033 DW=8, mode 0: load Tx_i=0xA5, select, master shifts 0x3C -> Rcvd_o=0x3C, RxValid_o=1 one cycle after 8th sample, miso sequence 1,0,1,0,0,1,0,1.
REQ-034 DW=16, CPOL=1 CPHA=1: master sends 0xBEEF, holding empty -> Rcvd_o=0xBEEF, miso all zeros, TxReady_o stays 1.
REQ-035 Two back-to-back words 0x11, 0x22 with no RxAck_i -> Rcvd_o=0x22, Ovr_o=1 (macro defined) / 0 (undefined); RxAck_i then clears RxValid_o and Ovr_o.
REQ-036 ss deasserted after 5 bits, then full word 0x81 -> RxValid_o asserts only once, Rcvd_o=0x81.
REQ-037 Rst_ni low for one cycle after 3 bits -> all outputs at reset values next cycle; following full word 0x7E received correctly.
REQ-038 ss[ID]==0 while another ss bit active -> miso high-impedance, no RxValid_o.
